i2c_scl_monitor: RTL and testbench

//  Receive-side counterpart of the bench clock source: consumes an incoming SCL, measures its
//  low/high phase lengths in system-clock cycles, and flags timing violations.
//  - Checks min-low, min-high and SCL stuck low against programmable limits.
//  - Sits on the I2C pin interface beside the master/slave core, as a checker/monitor.

---
 rtl/i2c_scl_monitor.sv | 95 +++++++++
 tb/tb_i2c_scl_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_monitor.sv
// i2c_scl_monitor: measures synchronized SCL low/high phase lengths and flags
// min-low, min-high and stuck-low timing violations.
module i2c_scl_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             scl_in,
  input  logic [CNT_W-1:0] min_low,
  input  logic [CNT_W-1:0] min_high,
  input  logic [CNT_W-1:0] timeout_lim,
  input  logic             clr,
  output logic             scl_sync,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             low_viol,
  output logic             high_viol,
  output logic             stuck_low
);
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEAS_LOW, MEAS_HIGH} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, rise, fall, stuck_hit, cap_low, cap_high;
  logic [CNT_W-1:0] cnt_q, cnt_d, cap, low_time_q, low_time_d, high_time_q, high_time_d;
  logic rise_q, fall_q, valid_q, valid_d, got_low_q, got_low_d;
  logic low_viol_q, low_viol_d, high_viol_q, high_viol_d, stuck_q, stuck_d;
  assign scl_sync   = sync_q[SYNC_STAGES-1];
  assign rise       = scl_sync & ~prev_q;
  assign fall       = ~scl_sync & prev_q;
  assign cap        = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign low_time   = low_time_q;
  assign high_time  = high_time_q;
  assign meas_valid = valid_q;
  assign low_viol   = low_viol_q;
  assign high_viol  = high_viol_q;
  assign stuck_low  = stuck_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      valid_q     <= 1'b0;
      got_low_q   <= 1'b0;
      low_time_q  <= '0;
      high_time_q <= '0;
      low_viol_q  <= 1'b0;
      high_viol_q <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], scl_in};
      prev_q      <= scl_sync;
      cnt_q       <= cnt_d;
      rise_q      <= rise;
      fall_q      <= fall;
      valid_q     <= valid_d;
      got_low_q   <= got_low_d;
      low_time_q  <= low_time_d;
      high_time_q <= high_time_d;
      low_viol_q  <= low_viol_d;
      high_viol_q <= high_viol_d;
      stuck_q     <= stuck_d;
    end
  end
  always_comb begin
    state_d = !enable ? IDLE : state_q == IDLE ? WAIT_EDGE :
              fall ? MEAS_LOW : rise ? MEAS_HIGH : state_q;
  end
  // the +1 is widened so a saturated counter cannot match the limit again
  assign stuck_hit = enable && timeout_lim != '0 && !scl_sync &&
                     (state_q == MEAS_LOW || state_q == WAIT_EDGE) &&
                     ({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, timeout_lim};
  always_comb begin
    cap_low     = enable && state_q == MEAS_LOW && rise;
    cap_high    = enable && state_q == MEAS_HIGH && fall;
    cnt_d       = (!enable || state_q == IDLE || rise || fall) ? '0 : cap;
    got_low_d   = (!enable || state_q == IDLE) ? 1'b0 : got_low_q | cap_low;
    valid_d     = cap_high && got_low_q;
    low_time_d  = cap_low ? cap : low_time_q;
    high_time_d = cap_high ? cap : high_time_q;
    low_viol_d  = (cap_low && cap < min_low) || (low_viol_q && !clr);
    high_viol_d = (cap_high && cap < min_high) || (high_viol_q && !clr);
    stuck_d     = stuck_hit || (stuck_q && !clr);
  end
endmodule

// File: tb/tb_i2c_scl_monitor.sv
// tb_i2c_scl_monitor: directed tests of the SCL monitor, 16-bit and 8-bit counter instances.
module tb_i2c_scl_monitor;
  logic clk = 0, rst_n = 0, enable = 0, scl_in = 1, clr = 0;
  logic [15:0] min_low = 0, min_high = 0, timeout_lim = 0;
  logic scl_sync, rise_pulse, fall_pulse, meas_valid, low_viol, high_viol, stuck_low;
  logic [15:0] low_time, high_time;
  logic scl_sync8, rise8, fall8, valid8, low_viol8, high_viol8, stuck8;
  logic [7:0] low_time8, high_time8;
  int vec = 0, errs = 0, n_valid = 0, n_rise = 0, n_fall = 0;

  i2c_scl_monitor u16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scl_in(scl_in), .min_low(min_low),
    .min_high(min_high), .timeout_lim(timeout_lim), .clr(clr), .scl_sync(scl_sync),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .low_time(low_time),
    .high_time(high_time), .meas_valid(meas_valid), .low_viol(low_viol),
    .high_viol(high_viol), .stuck_low(stuck_low));

  i2c_scl_monitor #(.CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scl_in(scl_in), .min_low(8'd0),
    .min_high(8'd0), .timeout_lim(8'd0), .clr(clr), .scl_sync(scl_sync8),
    .rise_pulse(rise8), .fall_pulse(fall8), .low_time(low_time8),
    .high_time(high_time8), .meas_valid(valid8), .low_viol(low_viol8),
    .high_viol(high_viol8), .stuck_low(stuck8));

  always #5 clk = ~clk;

  task cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_valid += int'(meas_valid); n_rise += int'(rise_pulse); n_fall += int'(fall_pulse);
    end
  endtask

  task drive(input logic lv, input int n);
    scl_in = lv;
    cyc(n);
  endtask

  task do_reset;
    rst_n = 0; enable = 0; clr = 0; scl_in = 1;
    min_low = 0; min_high = 0; timeout_lim = 0;
    cyc(3);
    rst_n = 1;
    cyc(2);
    n_valid = 0; n_rise = 0; n_fall = 0;
  endtask

  task test_reset;
    rst_n = 0; scl_in = 0;
    cyc(3);
    vec++; if (scl_sync !== 1'b1) begin errs++; $display("FAIL reset_scl_sync: got %b expected 1", scl_sync); end
    vec++; if ({rise_pulse, fall_pulse, meas_valid, low_viol, high_viol, stuck_low} !== 6'b0) begin errs++; $display("FAIL reset_flags: got %b expected 000000", {rise_pulse, fall_pulse, meas_valid, low_viol, high_viol, stuck_low}); end
    vec++; if (low_time !== 16'd0) begin errs++; $display("FAIL reset_low_time: got %0d expected 0", low_time); end
    vec++; if (high_time !== 16'd0) begin errs++; $display("FAIL reset_high_time: got %0d expected 0", high_time); end
    do_reset();
  endtask

  task test_nominal;
    do_reset();
    min_low = 400; min_high = 400; enable = 1;
    cyc(2);
    drive(1, 500);
    repeat (3) begin drive(0, 500); drive(1, 500); end
    vec++; if (low_time !== 16'd500) begin errs++; $display("FAIL nom_low_time: got %0d expected 500", low_time); end
    vec++; if (high_time !== 16'd500) begin errs++; $display("FAIL nom_high_time: got %0d expected 500", high_time); end
    vec++; if (n_valid !== 2) begin errs++; $display("FAIL nom_valid_count: got %0d expected 2", n_valid); end
    vec++; if (n_rise !== 3) begin errs++; $display("FAIL nom_rise_count: got %0d expected 3", n_rise); end
    vec++; if (n_fall !== 3) begin errs++; $display("FAIL nom_fall_count: got %0d expected 3", n_fall); end
    vec++; if ({low_viol, high_viol, stuck_low} !== 3'b0) begin errs++; $display("FAIL nom_no_viol: got %b expected 000", {low_viol, high_viol, stuck_low}); end
  endtask

  task test_low_viol;
    do_reset();
    min_low = 600; enable = 1;
    cyc(2);
    drive(1, 100); drive(0, 500); drive(1, 100);
    vec++; if (low_viol !== 1'b1) begin errs++; $display("FAIL lowv_set: got %b expected 1", low_viol); end
    vec++; if (high_viol !== 1'b0) begin errs++; $display("FAIL lowv_high_clear: got %b expected 0", high_viol); end
    vec++; if (low_time !== 16'd500) begin errs++; $display("FAIL lowv_low_time: got %0d expected 500", low_time); end
    clr = 1; cyc(1); clr = 0; cyc(1);
    vec++; if (low_viol !== 1'b0) begin errs++; $display("FAIL lowv_clr: got %b expected 0", low_viol); end
    drive(0, 500); drive(1, 100);
    vec++; if (low_viol !== 1'b1) begin errs++; $display("FAIL lowv_reset: got %b expected 1", low_viol); end
  endtask

  task test_clr_priority;
    drive(0, 500);
    scl_in = 1; clr = 1;
    cyc(3);
    clr = 0;
    cyc(2);
    vec++; if (low_viol !== 1'b1) begin errs++; $display("FAIL clr_vs_set: got %b expected 1", low_viol); end
  endtask

  task test_high_viol;
    do_reset();
    min_high = 600; enable = 1;
    cyc(2);
    drive(1, 100); drive(0, 200); drive(1, 500); drive(0, 10);
    vec++; if (high_viol !== 1'b1) begin errs++; $display("FAIL highv_set: got %b expected 1", high_viol); end
    vec++; if (high_time !== 16'd500) begin errs++; $display("FAIL highv_time: got %0d expected 500", high_time); end
    vec++; if (low_viol !== 1'b0) begin errs++; $display("FAIL highv_low_clear: got %b expected 0", low_viol); end
    vec++; if (n_valid !== 1) begin errs++; $display("FAIL highv_valid: got %0d expected 1", n_valid); end
  endtask

  task test_stuck;
    int k;
    do_reset();
    timeout_lim = 1000; enable = 1;
    cyc(2);
    drive(1, 50);
    scl_in = 0;
    k = 0;
    while (!fall_pulse && k < 10) begin cyc(1); k++; end
    vec++; if (k !== 3) begin errs++; $display("FAIL stuck_fall_latency: got %0d expected 3", k); end
    k = 0;
    while (!stuck_low && k < 1100) begin cyc(1); k++; end
    vec++; if (k !== 1000) begin errs++; $display("FAIL stuck_delay: got %0d expected 1000", k); end
    clr = 1; cyc(1); clr = 0;
    cyc(1500);
    vec++; if (stuck_low !== 1'b0) begin errs++; $display("FAIL stuck_once: got %b expected 0", stuck_low); end
    do_reset();
    enable = 1;
    cyc(2);
    drive(1, 50); drive(0, 2000);
    vec++; if (stuck_low !== 1'b0) begin errs++; $display("FAIL stuck_disabled: got %b expected 0", stuck_low); end
  endtask

  task test_edge_latency;
    logic ef, er;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      scl_in = (t == 1);
      for (int i = 1; i <= 5; i++) begin
        cyc(1);
        ef = (t == 0) && (i == 3);
        er = (t == 1) && (i == 3);
        vec++; if (fall_pulse !== ef) begin errs++; $display("FAIL edge_fall t=%0d i=%0d: got %b expected %b", t, i, fall_pulse, ef); end
        vec++; if (rise_pulse !== er) begin errs++; $display("FAIL edge_rise t=%0d i=%0d: got %b expected %b", t, i, rise_pulse, er); end
      end
    end
  endtask

  task test_enable_mid_high;
    do_reset();
    drive(0, 300); drive(1, 150);
    enable = 1;
    cyc(150);
    drive(0, 500); drive(1, 5);
    vec++; if (low_time !== 16'd500) begin errs++; $display("FAIL en_low_time: got %0d expected 500", low_time); end
    vec++; if (high_time !== 16'd0) begin errs++; $display("FAIL en_partial_high: got %0d expected 0", high_time); end
    vec++; if (n_valid !== 0) begin errs++; $display("FAIL en_no_early_valid: got %0d expected 0", n_valid); end
    cyc(495); drive(0, 5);
    vec++; if (high_time !== 16'd500) begin errs++; $display("FAIL en_high_time: got %0d expected 500", high_time); end
    vec++; if (n_valid !== 1) begin errs++; $display("FAIL en_first_valid: got %0d expected 1", n_valid); end
  endtask

  task test_saturation_and_reset;
    do_reset();
    enable = 1;
    cyc(2);
    drive(1, 50); drive(0, 300); drive(1, 5);
    vec++; if (low_time8 !== 8'd255) begin errs++; $display("FAIL sat_low_time8: got %0d expected 255", low_time8); end
    vec++; if (low_time !== 16'd300) begin errs++; $display("FAIL sat_low_time16: got %0d expected 300", low_time); end
    drive(0, 100);
    rst_n = 0;
    #1;
    vec++; if ({scl_sync, scl_sync8} !== 2'b11) begin errs++; $display("FAIL rst_mid_sync: got %b expected 11", {scl_sync, scl_sync8}); end
    vec++; if ({low_time, high_time, low_time8, high_time8} !== 48'd0) begin errs++; $display("FAIL rst_mid_times: got %h expected 0", {low_time, high_time, low_time8, high_time8}); end
    vec++; if ({rise_pulse, fall_pulse, meas_valid, low_viol, high_viol, stuck_low, rise8, fall8, valid8, low_viol8, high_viol8, stuck8} !== 12'b0) begin errs++; $display("FAIL rst_mid_flags: got %b expected 0", {rise_pulse, fall_pulse, meas_valid, low_viol, high_viol, stuck_low, rise8, fall8, valid8, low_viol8, high_viol8, stuck8}); end
    cyc(2);
    vec++; if ({rise_pulse, fall_pulse, rise8, fall8} !== 4'b0) begin errs++; $display("FAIL rst_no_pulses: got %b expected 0000", {rise_pulse, fall_pulse, rise8, fall8}); end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_low_viol();
    test_clr_priority();
    test_high_viol();
    test_stuck();
    test_edge_latency();
    test_enable_mid_high();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
